// File: rtl/trdb_pkg.sv
// Shared trace-debug types: packet format enums and encapsulation header layout.
package trdb_pkg;

    typedef enum logic [1:0] {
        F_OPT_EXT    = 2'h0,
        F_DIFF_DELTA = 2'h1,
        F_ADDR_ONLY  = 2'h2,
        F_SYNC       = 2'h3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START   = 2'h0,
        SF_TRAP    = 2'h1,
        SF_CONTEXT = 2'h2,
        SF_SUPPORT = 2'h3
    } trdb_f_sync_subformat_e;

    localparam int unsigned TRDB_HDR_LEN_W  = 5;
    localparam int unsigned TRDB_HDR_TS_BIT = 7;

    // Encapsulation header byte: {ts, flow, len}
    typedef struct packed {
        logic                      ts;
        logic [1:0]                flow;
        logic [TRDB_HDR_LEN_W-1:0] len;
    } trdb_encap_hdr_t;

    // Subformat is only meaningful for F_SYNC packets
    function automatic trdb_f_sync_subformat_e trdb_decode_subformat(input logic [7:0] b);
        if (trdb_format_e'(b[1:0]) == F_SYNC) begin
            return trdb_f_sync_subformat_e'(b[3:2]);
        end
        return SF_START;
    endfunction

endpackage

// File: rtl/trdb_payload_assembler.sv
// Byte-indexed payload register: cleared per packet, filled one byte per write.
module trdb_payload_assembler #(
    parameter int unsigned MAX_PAYLOAD_BYTES = 16,
    parameter int unsigned IDX_W             = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clr,
    input  logic                           we,
    input  logic [7:0]                     data,
    output logic [IDX_W-1:0]               idx,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] payload
);

    // Clear on a new header, otherwise write the byte at idx and advance
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx     <= '0;
            payload <= '0;
        end else if (clr) begin
            idx     <= '0;
            payload <= '0;
        end else if (we) begin
            payload[{idx, 3'b000} +: 8] <= data;
            idx                         <= idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/trdb_packet_decoder.sv
// Receive-side decoder: header + payload byte stream to one decoded packet per handshake.
module trdb_packet_decoder
    import trdb_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BYTES = 16,
    parameter int unsigned CNT_W             = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [7:0]                     data_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output trdb_format_e                   packet_format_o,
    output trdb_f_sync_subformat_e         packet_f_sync_subformat_o,
    output logic [1:0]                     flow_o,
    output logic [4:0]                     payload_len_o,
    output logic [8*MAX_PAYLOAD_BYTES-1:0] payload_o,
    output logic                           err_o,
    output logic [CNT_W-1:0]               dropped_cnt_o
);

    localparam int unsigned IDX_W = (MAX_PAYLOAD_BYTES > 1) ? $clog2(MAX_PAYLOAD_BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PAYLOAD,
        S_DRAIN,
        S_EMIT
    } state_e;

    state_e                    state;
    logic [TRDB_HDR_LEN_W-1:0] drain_cnt;
    logic [IDX_W-1:0]          idx;
    trdb_encap_hdr_t           hdr;
    logic                      xfer;
    logic                      hdr_err;
    logic                      last_byte;
    logic [7:0]                byte0;

    assign hdr       = trdb_encap_hdr_t'(data_i);
    assign xfer      = valid_i && ready_o;
    assign hdr_err   = hdr.ts || (hdr.len > TRDB_HDR_LEN_W'(MAX_PAYLOAD_BYTES));
    assign last_byte = (TRDB_HDR_LEN_W'(idx) == (payload_len_o - TRDB_HDR_LEN_W'(1)));
    // Byte 0 as it will be after this cycle's write, so decode can be registered with it
    assign byte0     = (idx == '0) ? data_i : payload_o[7:0];

    trdb_payload_assembler #(
        .MAX_PAYLOAD_BYTES (MAX_PAYLOAD_BYTES),
        .IDX_W             (IDX_W)
    ) u_assembler (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     ((state == S_IDLE) && xfer && !hdr_err && (hdr.len != '0)),
        .we      ((state == S_PAYLOAD) && xfer),
        .data    (data_i),
        .idx     (idx),
        .payload (payload_o)
    );

    // Packet FSM with registered handshake, decode and error outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state                     <= S_IDLE;
            ready_o                   <= 1'b0;
            valid_o                   <= 1'b0;
            err_o                     <= 1'b0;
            packet_format_o           <= F_OPT_EXT;
            packet_f_sync_subformat_o <= SF_START;
            flow_o                    <= '0;
            payload_len_o             <= '0;
            drain_cnt                 <= '0;
            dropped_cnt_o             <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    ready_o <= 1'b1;
                    if (xfer) begin
                        if (hdr_err) begin
                            err_o     <= 1'b1;
                            drain_cnt <= hdr.len;
                            if (dropped_cnt_o != '1) begin
                                dropped_cnt_o <= dropped_cnt_o + CNT_W'(1);
                            end
                            if (hdr.len != '0) begin
                                state <= S_DRAIN;
                            end
                        end else if (hdr.len != '0) begin
                            payload_len_o <= hdr.len;
                            flow_o        <= hdr.flow;
                            state         <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    ready_o <= 1'b1;
                    if (xfer && last_byte) begin
                        packet_format_o           <= trdb_format_e'(byte0[1:0]);
                        packet_f_sync_subformat_o <= trdb_decode_subformat(byte0);
                        valid_o                   <= 1'b1;
                        ready_o                   <= 1'b0;
                        state                     <= S_EMIT;
                    end
                end
                S_DRAIN: begin
                    ready_o <= 1'b1;
                    if (xfer) begin
                        if (drain_cnt == TRDB_HDR_LEN_W'(1)) begin
                            state <= S_IDLE;
                        end else begin
                            drain_cnt <= drain_cnt - TRDB_HDR_LEN_W'(1);
                        end
                    end
                end
                S_EMIT: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
